// File: rtl/mips8_pkg.sv
// mips8_pkg: sequencer states, opcode constants and opcode-class decode for the 8-bit MIPS datapath
package mips8_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_PAUSE  = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_ADDI  = 3'b001;
    localparam logic [2:0] OP_LW    = 3'b010;
    localparam logic [2:0] OP_SW    = 3'b011;
    localparam logic [2:0] OP_JUMP  = 3'b100;
    localparam logic [2:0] OP_HALT  = 3'b111;

    // C_FLOW covers JUMP and the two NOP opcodes: both only update the PC
    typedef enum logic [2:0] {C_ALU, C_LOAD, C_STORE, C_FLOW, C_HALT} cls_t;

    function automatic cls_t op_class(input logic [2:0] op);
        return (op == OP_RTYPE || op == OP_ADDI) ? C_ALU :
               (op == OP_LW)                     ? C_LOAD :
               (op == OP_SW)                     ? C_STORE :
               (op == OP_HALT)                   ? C_HALT : C_FLOW;
    endfunction

endpackage

// File: rtl/mips8_seq_counter.sv
// mips8_seq_counter: saturating retired-instruction counter with synchronous clear
module mips8_seq_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && !(&count))
            count <= count + W'(1);

endmodule

// File: rtl/mips8_sequencer.sv
// mips8_sequencer: multi-cycle FETCH..WB control sequencer with run/step/halt.
// Define SEQ_BKPT_EN to enable the PC breakpoint (bkpt_addr/bkpt_valid).
module mips8_sequencer
    import mips8_pkg::*;
#(
    parameter logic [7:0] PC_RESET = 8'h00,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             halt_req,
    input  logic             step_mode,
    input  logic             step,
    input  logic [7:0]       instr_in,
    input  logic [7:0]       next_addr_in,
    input  logic [7:0]       bkpt_addr,
    input  logic             bkpt_valid,
    output logic [7:0]       pc_out,
    output logic [7:0]       ir_out,
    output logic             reg_we,
    output logic             mem_re,
    output logic             mem_we,
    output logic [2:0]       state_out,
    output logic             busy,
    output logic             halted,
    output logic             retire,
    output logic [CNT_W-1:0] instr_count
);

    state_t state, nxt, bnd_st;
    cls_t   cls;
    logic   go, bnd, bkpt_hit;

    assign cls = op_class(ir_out[7:5]);
    assign go  = start && (state == S_IDLE || state == S_HALT);

`ifdef SEQ_BKPT_EN
    assign bkpt_hit = bkpt_valid && next_addr_in == bkpt_addr;
`else
    logic unused_bkpt;
    assign unused_bkpt = ^{bkpt_addr, bkpt_valid};
    assign bkpt_hit    = 1'b0;
`endif

    assign bnd_st = halt_req ? S_HALT : (step_mode || bkpt_hit) ? S_PAUSE : S_FETCH;

    always_comb begin
        nxt = state;
        bnd = 1'b0;
        case (state)
            S_IDLE:   nxt = go ? S_FETCH : S_IDLE;
            S_FETCH:  nxt = S_DECODE;
            S_DECODE: nxt = (cls == C_HALT) ? S_HALT : S_EXEC;
            S_EXEC: begin
                bnd = (cls == C_FLOW);
                nxt = (cls == C_ALU) ? S_WB : (cls inside {C_LOAD, C_STORE}) ? S_MEM : bnd_st;
            end
            S_MEM: begin
                bnd = (cls == C_STORE);
                nxt = bnd ? bnd_st : S_WB;
            end
            S_WB: begin
                bnd = 1'b1;
                nxt = bnd_st;
            end
            S_PAUSE:  nxt = halt_req ? S_HALT : step ? S_FETCH : S_PAUSE;
            S_HALT:   nxt = go ? S_FETCH : S_HALT;
            default:  nxt = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so each is high for exactly the cycle it belongs to
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state  <= S_IDLE;
            pc_out <= PC_RESET;
            ir_out <= '0;
            reg_we <= 1'b0;
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            retire <= 1'b0;
        end else begin
            state <= nxt;
            if (go)
                pc_out <= PC_RESET;
            else if (bnd)
                pc_out <= next_addr_in;
            if (state == S_FETCH)
                ir_out <= instr_in;
            reg_we <= (nxt == S_WB);
            mem_re <= (nxt == S_MEM);
            mem_we <= (nxt == S_MEM) && (cls == C_STORE);
            retire <= (nxt == S_WB) || ((nxt == S_MEM) && (cls == C_STORE)) ||
                      ((nxt == S_EXEC) && (cls == C_FLOW));
        end

    assign state_out = state;
    assign busy      = (state >= S_FETCH) && (state <= S_WB);
    assign halted    = (state == S_HALT);

    mips8_seq_counter #(.W(CNT_W)) u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (go),
        .inc     (retire),
        .count   (instr_count)
    );

endmodule

// File: tb/tb_mips8_sequencer.sv
// tb_mips8_sequencer: table-driven instruction timing vectors plus step/halt/reset/breakpoint sequences
module tb_mips8_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0, halt_req = 1'b0, step_mode = 1'b0, step = 1'b0;
    logic [7:0]  instr_in = '0, next_addr_in = '0, bkpt_addr = '0;
    logic        bkpt_valid = 1'b0;
    logic [7:0]  pc_out, ir_out;
    logic        reg_we, mem_re, mem_we, busy, halted, retire;
    logic [2:0]  state_out;
    logic [15:0] instr_count;

    int n_chk = 0;
    int n_fail = 0;

    mips8_sequencer #(.PC_RESET(8'h00), .CNT_W(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .halt_req     (halt_req),
        .step_mode    (step_mode),
        .step         (step),
        .instr_in     (instr_in),
        .next_addr_in (next_addr_in),
        .bkpt_addr    (bkpt_addr),
        .bkpt_valid   (bkpt_valid),
        .pc_out       (pc_out),
        .ir_out       (ir_out),
        .reg_we       (reg_we),
        .mem_re       (mem_re),
        .mem_we       (mem_we),
        .state_out    (state_out),
        .busy         (busy),
        .halted       (halted),
        .retire       (retire),
        .instr_count  (instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] instr;
        logic [7:0] nxt;
        int         lat;
        logic [7:0] rw;
        logic [7:0] mr;
        logic [7:0] mw;
        logic [7:0] pc;
        int         cnt;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        start    = 1'b0;
        step     = 1'b0;
        halt_req = 1'b0;
        #3;
        chk("rst_state", 32'(state_out), 32'd0);
        chk("rst_pc", 32'(pc_out), 32'h00);
        chk("rst_ir", 32'(ir_out), 32'h00);
        chk("rst_strobes", 32'({reg_we, mem_re, mem_we}), 32'd0);
        chk("rst_flags", 32'({busy, halted, retire}), 32'd0);
        chk("rst_count", 32'(instr_count), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rw, mr, mw;
        int lat;
        bit done;
        tbl[0] = '{8'h05, 8'h01, 4, 8'h08, 8'h00, 8'h00, 8'h01, 1};
        tbl[1] = '{8'h4A, 8'h02, 5, 8'h10, 8'h08, 8'h00, 8'h02, 2};
        tbl[2] = '{8'h6A, 8'h03, 4, 8'h00, 8'h08, 8'h08, 8'h03, 3};
        tbl[3] = '{8'h80, 8'h20, 3, 8'h00, 8'h00, 8'h00, 8'h20, 4};
        tbl[4] = '{8'h25, 8'h21, 4, 8'h08, 8'h00, 8'h00, 8'h21, 5};
        tbl[5] = '{8'hA0, 8'h22, 3, 8'h00, 8'h00, 8'h00, 8'h22, 6};
        tbl[6] = '{8'h9F, 8'hFF, 3, 8'h00, 8'h00, 8'h00, 8'hFF, 7};
        tbl[7] = '{8'hC0, 8'h00, 3, 8'h00, 8'h00, 8'h00, 8'h00, 8};

        tick();
        do_reset();

        go();
        for (int k = 0; k < 8; k++) begin
            instr_in     = tbl[k].instr;
            next_addr_in = tbl[k].nxt;
            rw = '0; mr = '0; mw = '0; lat = 0;
            for (int c = 1; c <= 8 && lat == 0; c++) begin
                rw[c-1] = reg_we;
                mr[c-1] = mem_re;
                mw[c-1] = mem_we;
                if (retire) lat = c;
                tick();
            end
            chk($sformatf("v%0d_latency", k), 32'(lat), 32'(tbl[k].lat));
            chk($sformatf("v%0d_reg_we", k), 32'(rw), 32'(tbl[k].rw));
            chk($sformatf("v%0d_mem_re", k), 32'(mr), 32'(tbl[k].mr));
            chk($sformatf("v%0d_mem_we", k), 32'(mw), 32'(tbl[k].mw));
            chk($sformatf("v%0d_pc", k), 32'(pc_out), 32'(tbl[k].pc));
            chk($sformatf("v%0d_count", k), 32'(instr_count), 32'(tbl[k].cnt));
        end

        // single-step through three NOPs
        do_reset();
        step_mode = 1'b1;
        instr_in = 8'hA0;
        next_addr_in = 8'h01;
        go();
        tick();
        tick();
        chk("step_retire", 32'(retire), 32'd1);
        tick();
        chk("step_pause1", 32'(state_out), 32'd6);
        chk("step_pc1", 32'(pc_out), 32'h01);
        chk("step_busy", 32'(busy), 32'd0);
        tick();
        tick();
        chk("step_hold", 32'(state_out), 32'd6);
        next_addr_in = 8'h02;
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("step_fetch", 32'(state_out), 32'd1);
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        tick();
        chk("step_pause2", 32'(state_out), 32'd6);
        chk("step_pc2", 32'(pc_out), 32'h02);
        chk("step_count2", 32'(instr_count), 32'd2);
        next_addr_in = 8'h03;
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        tick();
        tick();
        chk("step_pause3", 32'(state_out), 32'd6);
        chk("step_count3", 32'(instr_count), 32'd3);
        step_mode = 1'b0;

        // halt requested during EXEC, restart, then HALT opcode
        do_reset();
        instr_in = 8'h05;
        next_addr_in = 8'h01;
        go();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_start_ignored", 32'(state_out), 32'd2);
        tick();
        halt_req = 1'b1;
        tick();
        chk("halt_wb_reg_we", 32'(reg_we), 32'd1);
        chk("halt_wb_retire", 32'(retire), 32'd1);
        tick();
        chk("halt_state", 32'(state_out), 32'd7);
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_pc", 32'(pc_out), 32'h01);
        chk("halt_count", 32'(instr_count), 32'd1);
        chk("halt_reg_we_off", 32'(reg_we), 32'd0);
        halt_req = 1'b0;
        tick();
        tick();
        chk("halt_pc_hold", 32'(pc_out), 32'h01);
        go();
        chk("restart_state", 32'(state_out), 32'd1);
        chk("restart_pc", 32'(pc_out), 32'h00);
        chk("restart_count", 32'(instr_count), 32'd0);
        instr_in = 8'hE0;
        tick();
        tick();
        chk("hop_state", 32'(state_out), 32'd7);
        chk("hop_count", 32'(instr_count), 32'd0);
        chk("hop_pc", 32'(pc_out), 32'h00);

        // reset dropped during MEM of SW
        do_reset();
        instr_in = 8'h6A;
        next_addr_in = 8'h01;
        go();
        tick();
        tick();
        tick();
        chk("sw_mem_we", 32'(mem_we), 32'd1);
        chk("sw_mem_re", 32'(mem_re), 32'd1);
        do_reset();

        // breakpoint at PC 3 while running NOPs
        bkpt_addr = 8'h03;
        bkpt_valid = 1'b1;
        instr_in = 8'hA0;
        go();
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            next_addr_in = pc_out + 8'd1;
            tick();
            if (state_out == 3'd6 || instr_count == 16'd5) done = 1'b1;
        end
`ifdef SEQ_BKPT_EN
        chk("bkpt_pause", 32'(state_out), 32'd6);
        chk("bkpt_pc", 32'(pc_out), 32'h03);
        chk("bkpt_count", 32'(instr_count), 32'd3);
        next_addr_in = 8'h04;
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        tick();
        tick();
        chk("bkpt_resume_state", 32'(state_out), 32'd1);
        chk("bkpt_resume_pc", 32'(pc_out), 32'h04);
`else
        chk("nobkpt_state", 32'(state_out), 32'd1);
        chk("nobkpt_pc", 32'(pc_out), 32'h05);
        chk("nobkpt_count", 32'(instr_count), 32'd5);
`endif
        bkpt_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
